tag_ram_assoc: RTL and testbench
================================

Name: tag_ram_assoc

Overview:
Clocked, N-way set-associative tag store for the cache controller. It holds a tag, a valid bit and a dirty bit per way, and keeps a round-robin replacement pointer per set. Lookups return hit, hit way and replacement victim one cycle later. A flush engine walks every entry and hands dirty lines to the write-back path through a valid/ready handshake.

Parameters:
INDEX_LENGTH, 4, set index width; SETS = 2**INDEX_LENGTH.
TAG_LENGTH, 22, tag width in bits.
WAYS, 2, associativity; power of two, 1..8. WAY_W = max(1, log2(WAYS)), derived locally.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
index_i  in  INDEX_LENGTH  set index for lookup, fill and mark-dirty
tag_i  in  TAG_LENGTH  tag for lookup compare or fill write
way_i  in  WAY_W  target way for fill and mark-dirty
lookup_i  in  1  lookup request
fill_i  in  1  write tag_i into (index_i, way_i); valid=1, dirty=dirty_i
dirty_i  in  1  dirty value written on fill
mark_dirty_i  in  1  set dirty on (index_i, way_i) if valid
flush_i  in  1  start flush scan
rsp_valid_o  out  1  one-cycle pulse: lookup result valid
hit_o  out  1  lookup hit
hit_way_o  out  WAY_W  way that hit
victim_way_o  out  WAY_W  way to replace on miss
victim_valid_o  out  1  victim entry valid
victim_dirty_o  out  1  victim entry dirty
victim_tag_o  out  TAG_LENGTH  victim tag, for write-back address
wb_valid_o  out  1  dirty line offered for write-back
wb_ready_i  in  1  write-back path accepts
wb_index_o  out  INDEX_LENGTH  write-back set
wb_way_o  out  WAY_W  write-back way
wb_tag_o  out  TAG_LENGTH  write-back tag
busy_o  out  1  flush in progress
flush_done_o  out  1  one-cycle pulse at end of flush

Behaviour:
- Reset (synchronous, active-high): all valid, dirty and rr pointers = 0; FSM goes to IDLE. All outputs = 0. Tag storage is not reset; a hit always requires valid=1.
- Reset asserted mid-flush aborts the flush. No flush_done_o pulse. wb_valid_o = 0 in the next cycle.
- Command priority in IDLE, one command per cycle: flush_i > fill_i > mark_dirty_i > lookup_i. Lower-priority commands in the same cycle are dropped.
- While busy_o = 1, all commands except rst are ignored.
- Lookup: request in cycle t; in cycle t+1, rsp_valid_o = 1 for exactly one cycle.
  - hit_o = OR over ways of (valid & tag == tag_i). hit_way_o = lowest matching way; 0 on miss.
  - Victim = lowest invalid way if any exists, else rr[index].
  - victim_valid_o, victim_dirty_o and victim_tag_o come from that victim way.
  - Result outputs hold their values until the next accepted lookup.
- Fill: write in the same cycle edge. rr[index_i] <= (way_i + 1) mod WAYS. A lookup issued the following cycle sees the new entry.
- Mark-dirty: sets dirty only if the entry is valid; otherwise it is a no-op. rr is unchanged.
- Flush FSM: IDLE -> SCAN -> (OFFER) -> SCAN ... -> DONE -> IDLE.
  - Scan order: set 0 way 0, set 0 way 1, ..., set SETS-1 way WAYS-1.
  - SCAN costs one cycle per entry. A clean or invalid entry advances with no output.
  - A valid and dirty entry moves to OFFER: wb_valid_o = 1, and wb_index_o, wb_way_o, wb_tag_o stay stable until wb_ready_i = 1.
  - On handshake: dirty <= 0, valid kept, FSM advances. wb_ready_i while wb_valid_o = 0 is ignored.
  - After the last entry, DONE lasts one cycle: flush_done_o = 1 and busy_o = 0 in that cycle. Then IDLE.
  - busy_o = 1 from the cycle after flush_i is accepted through the final SCAN/OFFER cycle.
- Flush latency with no dirty lines: exactly SETS*WAYS cycles busy, then 1 DONE cycle.
- Counter wrap: the entry counter is INDEX_LENGTH+WAY_W bits; the last entry is detected explicitly and no wrap into set 0 occurs.
- WAYS = 1: way fields are 1 bit, ignored, and driven as 0. Victim is always way 0.

Test Plan:
- Reset, then lookup index 3 tag 0x12345 -> t+1: rsp_valid_o = 1, hit_o = 0, victim_way_o = 0, victim_valid_o = 0.
- Fill (3, way 0, tag 0x12345, dirty 0); fill (3, way 1, tag 0x0ABCD, dirty 1); lookup 0x0ABCD -> hit_o = 1, hit_way_o = 1. Lookup 0x3FFFF -> miss, victim_way_o = 0 (rr = 2 mod 2), victim_valid_o = 1, victim_dirty_o = 0, victim_tag_o = 0x12345.
- fill_i and lookup_i in the same cycle -> fill performed, no rsp_valid_o. Mark-dirty on an invalid entry -> later lookup victim_dirty_o = 0.
- Dirty lines at (1,0) and (15,1), wb_ready_i held low 5 cycles at the first offer -> wb_valid_o held with wb_index_o = 1, wb_way_o = 0, tag stable. Both handshakes occur. flush_done_o pulses once. Subsequent lookups show valid = 1, dirty = 0.
- Flush with no dirty lines -> busy_o high exactly 32 cycles, then a one-cycle flush_done_o. lookup_i during busy -> no response.
- rst asserted during OFFER -> wb_valid_o = 0 and busy_o = 0 the next cycle, no flush_done_o, all lookups miss.

Source files
------------

// File: rtl/tag_ram_assoc_if.sv
// Command, lookup-response and write-back signals of the set-associative tag store.
`timescale 1ns/1ps
interface tag_ram_assoc_if #(
   parameter int INDEX_LENGTH = 4,
   parameter int TAG_LENGTH   = 22,
   parameter int WAYS         = 2,
   parameter int WAY_W        = (WAYS > 1) ? $clog2(WAYS) : 1
);
   logic [INDEX_LENGTH-1:0] index_i;
   logic [TAG_LENGTH-1:0]   tag_i;
   logic [WAY_W-1:0]        way_i;
   logic                    lookup_i;
   logic                    fill_i;
   logic                    dirty_i;
   logic                    mark_dirty_i;
   logic                    flush_i;
   logic                    rsp_valid_o;
   logic                    hit_o;
   logic [WAY_W-1:0]        hit_way_o;
   logic [WAY_W-1:0]        victim_way_o;
   logic                    victim_valid_o;
   logic                    victim_dirty_o;
   logic [TAG_LENGTH-1:0]   victim_tag_o;
   logic                    wb_valid_o;
   logic                    wb_ready_i;
   logic [INDEX_LENGTH-1:0] wb_index_o;
   logic [WAY_W-1:0]        wb_way_o;
   logic [TAG_LENGTH-1:0]   wb_tag_o;
   logic                    busy_o;
   logic                    flush_done_o;

   modport master (
      output index_i, tag_i, way_i, lookup_i, fill_i, dirty_i, mark_dirty_i, flush_i, wb_ready_i,
      input  rsp_valid_o, hit_o, hit_way_o, victim_way_o, victim_valid_o, victim_dirty_o,
             victim_tag_o, wb_valid_o, wb_index_o, wb_way_o, wb_tag_o, busy_o, flush_done_o
   );

   modport slave (
      input  index_i, tag_i, way_i, lookup_i, fill_i, dirty_i, mark_dirty_i, flush_i, wb_ready_i,
      output rsp_valid_o, hit_o, hit_way_o, victim_way_o, victim_valid_o, victim_dirty_o,
             victim_tag_o, wb_valid_o, wb_index_o, wb_way_o, wb_tag_o, busy_o, flush_done_o
   );
endinterface

// File: rtl/tag_ram_assoc.sv
// N-way set-associative tag store with round-robin replacement and a flush engine
// that offers dirty lines to the write-back path one at a time.
`timescale 1ns/1ps
module tag_ram_assoc #(
   parameter int INDEX_LENGTH = 4,
   parameter int TAG_LENGTH   = 22,
   parameter int WAYS         = 2
) (
   input logic            clk,
   input logic            rst,
   tag_ram_assoc_if.slave bus
);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int SETS  = 2 ** INDEX_LENGTH;

   typedef enum logic [1:0] {IDLE, SCAN, OFFER, DONE} state_t;

   logic [TAG_LENGTH-1:0]   tag_mem [SETS][WAYS];
   logic [WAYS-1:0]         valid_q [SETS];
   logic [WAYS-1:0]         dirty_q [SETS];
   logic [WAY_W-1:0]        rr_q    [SETS];

   state_t                  state_q;
   logic [INDEX_LENGTH-1:0] scan_set_q;
   logic [WAY_W-1:0]        scan_way_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    wb_valid_q;
   logic [INDEX_LENGTH-1:0] wb_index_q;
   logic [WAY_W-1:0]        wb_way_q;
   logic [TAG_LENGTH-1:0]   wb_tag_q;

   logic                    vld_p1;
   logic                    hit_p1;
   logic [WAY_W-1:0]        hit_way_p1;
   logic [WAY_W-1:0]        vic_way_p1;
   logic                    vic_valid_p1;
   logic                    vic_dirty_p1;
   logic [TAG_LENGTH-1:0]   vic_tag_p1;

   logic [INDEX_LENGTH-1:0] idx;
   logic [WAY_W-1:0]        way_sel;
   logic                    lk_hit;
   logic [WAY_W-1:0]        lk_hit_way;
   logic                    lk_has_inv;
   logic [WAY_W-1:0]        lk_inv_way;
   logic [WAY_W-1:0]        lk_vic_way;
   logic                    scan_last;
   logic                    scan_dirty;
   logic                    idle_cmd;

   function automatic logic [WAY_W-1:0] rr_next(input logic [WAY_W-1:0] w);
      if (WAYS == 1) return '0;
      return w + 1'b1;
   endfunction

   assign idx       = bus.index_i;
   assign way_sel   = (WAYS > 1) ? bus.way_i : '0;
   assign idle_cmd  = (state_q == IDLE);
   assign scan_last = (scan_set_q == INDEX_LENGTH'(SETS - 1)) && (scan_way_q == WAY_W'(WAYS - 1));
   assign scan_dirty = valid_q[scan_set_q][scan_way_q] && dirty_q[scan_set_q][scan_way_q];

   // Descending scan so the lowest matching / lowest invalid way wins.
   always_comb begin
      lk_hit     = 1'b0;
      lk_hit_way = '0;
      lk_has_inv = 1'b0;
      lk_inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[idx][w] && (tag_mem[idx][w] == bus.tag_i)) begin
            lk_hit     = 1'b1;
            lk_hit_way = WAY_W'(w);
         end
         if (!valid_q[idx][w]) begin
            lk_has_inv = 1'b1;
            lk_inv_way = WAY_W'(w);
         end
      end
      lk_vic_way = lk_has_inv ? lk_inv_way : rr_q[idx];
   end

   // Tag array carries no reset; valid qualifies every use.
   always_ff @(posedge clk) begin
      if (idle_cmd && !bus.flush_i && bus.fill_i)
         tag_mem[idx][way_sel] <= bus.tag_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            rr_q[s]    <= '0;
         end
         state_q      <= IDLE;
         scan_set_q   <= '0;
         scan_way_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         wb_valid_q   <= 1'b0;
         wb_index_q   <= '0;
         wb_way_q     <= '0;
         wb_tag_q     <= '0;
         vld_p1       <= 1'b0;
         hit_p1       <= 1'b0;
         hit_way_p1   <= '0;
         vic_way_p1   <= '0;
         vic_valid_p1 <= 1'b0;
         vic_dirty_p1 <= 1'b0;
         vic_tag_p1   <= '0;
      end else begin
         vld_p1 <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.flush_i) begin
                  state_q    <= SCAN;
                  busy_q     <= 1'b1;
                  scan_set_q <= '0;
                  scan_way_q <= '0;
               end else if (bus.fill_i) begin
                  valid_q[idx][way_sel] <= 1'b1;
                  dirty_q[idx][way_sel] <= bus.dirty_i;
                  rr_q[idx]             <= rr_next(way_sel);
               end else if (bus.mark_dirty_i) begin
                  if (valid_q[idx][way_sel])
                     dirty_q[idx][way_sel] <= 1'b1;
               end else if (bus.lookup_i) begin
                  // Lookup stage p0 -> p1 boundary
                  vld_p1       <= 1'b1;
                  hit_p1       <= lk_hit;
                  hit_way_p1   <= lk_hit_way;
                  vic_way_p1   <= lk_vic_way;
                  vic_valid_p1 <= valid_q[idx][lk_vic_way];
                  vic_dirty_p1 <= dirty_q[idx][lk_vic_way];
                  vic_tag_p1   <= tag_mem[idx][lk_vic_way];
               end
            end
            SCAN: begin
               if (scan_dirty) begin
                  state_q    <= OFFER;
                  wb_valid_q <= 1'b1;
                  wb_index_q <= scan_set_q;
                  wb_way_q   <= scan_way_q;
                  wb_tag_q   <= tag_mem[scan_set_q][scan_way_q];
               end else if (scan_last) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (scan_way_q == WAY_W'(WAYS - 1)) begin
                  scan_way_q <= '0;
                  scan_set_q <= scan_set_q + 1'b1;
               end else begin
                  scan_way_q <= scan_way_q + 1'b1;
               end
            end
            OFFER: begin
               if (bus.wb_ready_i) begin
                  dirty_q[scan_set_q][scan_way_q] <= 1'b0;
                  wb_valid_q <= 1'b0;
                  if (scan_last) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= SCAN;
                     if (scan_way_q == WAY_W'(WAYS - 1)) begin
                        scan_way_q <= '0;
                        scan_set_q <= scan_set_q + 1'b1;
                     end else begin
                        scan_way_q <= scan_way_q + 1'b1;
                     end
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.rsp_valid_o    = vld_p1;
   assign bus.hit_o          = hit_p1;
   assign bus.hit_way_o      = hit_way_p1;
   assign bus.victim_way_o   = vic_way_p1;
   assign bus.victim_valid_o = vic_valid_p1;
   assign bus.victim_dirty_o = vic_dirty_p1;
   assign bus.victim_tag_o   = vic_tag_p1;
   assign bus.wb_valid_o     = wb_valid_q;
   assign bus.wb_index_o     = wb_index_q;
   assign bus.wb_way_o       = wb_way_q;
   assign bus.wb_tag_o       = wb_tag_q;
   assign bus.busy_o         = busy_q;
   assign bus.flush_done_o   = done_q;
endmodule

// File: tb/tb_tag_ram_assoc.sv
// Directed-vector bench for tag_ram_assoc: lookup/fill/mark-dirty, flush with
// write-back back-pressure, clean flush timing and reset during an offer.
`timescale 1ns/1ps
module tb_tag_ram_assoc;
   localparam int INDEX_LENGTH = 4;
   localparam int TAG_LENGTH   = 22;
   localparam int WAYS         = 2;

   logic clk = 1'b0;
   logic rst;
   int   n_vec    = 0;
   int   n_err    = 0;
   int   done_cnt = 0;
   int   hs_cnt   = 0;

   tag_ram_assoc_if #(.INDEX_LENGTH(INDEX_LENGTH), .TAG_LENGTH(TAG_LENGTH), .WAYS(WAYS)) bus ();

   tag_ram_assoc #(.INDEX_LENGTH(INDEX_LENGTH), .TAG_LENGTH(TAG_LENGTH), .WAYS(WAYS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.flush_done_o) done_cnt++;
      if (bus.wb_valid_o && bus.wb_ready_i) hs_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_cmds();
      bus.lookup_i     = 1'b0;
      bus.fill_i       = 1'b0;
      bus.mark_dirty_i = 1'b0;
      bus.flush_i      = 1'b0;
      bus.dirty_i      = 1'b0;
   endtask

   task automatic lookup(input logic [3:0] idx, input logic [21:0] tag);
      bus.index_i  = idx;
      bus.tag_i    = tag;
      bus.lookup_i = 1'b1;
      step();
      clear_cmds();
   endtask

   task automatic fill(input logic [3:0] idx, input logic way, input logic [21:0] tag, input logic d);
      bus.index_i = idx;
      bus.way_i   = way;
      bus.tag_i   = tag;
      bus.dirty_i = d;
      bus.fill_i  = 1'b1;
      step();
      clear_cmds();
   endtask

   task automatic mark(input logic [3:0] idx, input logic way);
      bus.index_i      = idx;
      bus.way_i        = way;
      bus.mark_dirty_i = 1'b1;
      step();
      clear_cmds();
   endtask

   task automatic wait_wb(input string tag);
      int i;
      for (i = 0; i < 200 && !bus.wb_valid_o; i++) step();
      check_eq(tag, 32'(bus.wb_valid_o), 32'd1);
   endtask

   int  busy_cnt;
   bit  saw_rsp;
   int  done_before;

   initial begin
      rst = 1'b1;
      clear_cmds();
      bus.index_i    = '0;
      bus.tag_i      = '0;
      bus.way_i      = '0;
      bus.wb_ready_i = 1'b0;
      step();
      step();
      check_eq("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      check_eq("rst_hit", 32'(bus.hit_o), 32'd0);
      check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
      check_eq("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
      check_eq("rst_done", 32'(bus.flush_done_o), 32'd0);
      rst = 1'b0;
      step();

      // Lookup into an empty set
      lookup(4'd3, 22'h12345);
      check_eq("empty_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      check_eq("empty_hit", 32'(bus.hit_o), 32'd0);
      check_eq("empty_vic_way", 32'(bus.victim_way_o), 32'd0);
      check_eq("empty_vic_valid", 32'(bus.victim_valid_o), 32'd0);
      step();
      check_eq("rsp_pulse_end", 32'(bus.rsp_valid_o), 32'd0);

      // Two fills, hit on way 1, miss with rr victim
      fill(4'd3, 1'b0, 22'h12345, 1'b0);
      fill(4'd3, 1'b1, 22'h0ABCD, 1'b1);
      lookup(4'd3, 22'h0ABCD);
      check_eq("hit1_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      check_eq("hit1_hit", 32'(bus.hit_o), 32'd1);
      check_eq("hit1_way", 32'(bus.hit_way_o), 32'd1);
      lookup(4'd3, 22'h12345);
      check_eq("hit0_way", 32'(bus.hit_way_o), 32'd0);
      lookup(4'd3, 22'h3FFFF);
      check_eq("miss_hit", 32'(bus.hit_o), 32'd0);
      check_eq("miss_hit_way", 32'(bus.hit_way_o), 32'd0);
      check_eq("miss_vic_way", 32'(bus.victim_way_o), 32'd0);
      check_eq("miss_vic_valid", 32'(bus.victim_valid_o), 32'd1);
      check_eq("miss_vic_dirty", 32'(bus.victim_dirty_o), 32'd0);
      check_eq("miss_vic_tag", 32'(bus.victim_tag_o), 32'h12345);
      step();
      check_eq("result_hold", 32'(bus.victim_tag_o), 32'h12345);

      // Fill wins over a same-cycle lookup
      bus.index_i  = 4'd5;
      bus.way_i    = 1'b1;
      bus.tag_i    = 22'h00777;
      bus.fill_i   = 1'b1;
      bus.lookup_i = 1'b1;
      step();
      clear_cmds();
      check_eq("fill_lookup_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
      lookup(4'd5, 22'h00777);
      check_eq("fill_seen_hit", 32'(bus.hit_o), 32'd1);
      check_eq("fill_seen_way", 32'(bus.hit_way_o), 32'd1);

      // Mark-dirty on an invalid entry does nothing
      mark(4'd5, 1'b0);
      lookup(4'd5, 22'h00001);
      check_eq("mark_inv_vic_way", 32'(bus.victim_way_o), 32'd0);
      check_eq("mark_inv_vic_valid", 32'(bus.victim_valid_o), 32'd0);
      check_eq("mark_inv_vic_dirty", 32'(bus.victim_dirty_o), 32'd0);

      // Flush with two dirty lines and write-back back-pressure
      rst = 1'b1;
      step();
      rst = 1'b0;
      fill(4'd1, 1'b0, 22'h11111, 1'b1);
      fill(4'd1, 1'b1, 22'h0000A, 1'b0);
      fill(4'd15, 1'b1, 22'h2FFFF, 1'b1);
      fill(4'd15, 1'b0, 22'h00005, 1'b0);
      fill(4'd7, 1'b0, 22'h00042, 1'b0);
      bus.wb_ready_i = 1'b1;
      step();
      bus.wb_ready_i = 1'b0;
      check_eq("idle_ready_no_hs", 32'(hs_cnt), 32'd0);
      done_before = done_cnt;
      bus.flush_i = 1'b1;
      step();
      clear_cmds();
      check_eq("flush_busy", 32'(bus.busy_o), 32'd1);
      wait_wb("offer1_valid");
      check_eq("offer1_index", 32'(bus.wb_index_o), 32'd1);
      check_eq("offer1_way", 32'(bus.wb_way_o), 32'd0);
      check_eq("offer1_tag", 32'(bus.wb_tag_o), 32'h11111);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("offer1_hold_valid", 32'(bus.wb_valid_o), 32'd1);
         check_eq("offer1_hold_index", 32'(bus.wb_index_o), 32'd1);
         check_eq("offer1_hold_tag", 32'(bus.wb_tag_o), 32'h11111);
      end
      bus.wb_ready_i = 1'b1;
      step();
      bus.wb_ready_i = 1'b0;
      check_eq("offer1_drop", 32'(bus.wb_valid_o), 32'd0);
      wait_wb("offer2_valid");
      check_eq("offer2_index", 32'(bus.wb_index_o), 32'd15);
      check_eq("offer2_way", 32'(bus.wb_way_o), 32'd1);
      check_eq("offer2_tag", 32'(bus.wb_tag_o), 32'h2FFFF);
      bus.wb_ready_i = 1'b1;
      step();
      bus.wb_ready_i = 1'b0;
      check_eq("flush1_done", 32'(bus.flush_done_o), 32'd1);
      check_eq("flush1_busy_low", 32'(bus.busy_o), 32'd0);
      step();
      check_eq("flush1_done_pulse", 32'(bus.flush_done_o), 32'd0);
      check_eq("flush1_done_count", 32'(done_cnt - done_before), 32'd1);
      check_eq("flush1_hs_count", 32'(hs_cnt), 32'd2);
      lookup(4'd1, 22'h00003);
      check_eq("post_s1_vic_way", 32'(bus.victim_way_o), 32'd0);
      check_eq("post_s1_vic_valid", 32'(bus.victim_valid_o), 32'd1);
      check_eq("post_s1_vic_dirty", 32'(bus.victim_dirty_o), 32'd0);
      check_eq("post_s1_vic_tag", 32'(bus.victim_tag_o), 32'h11111);
      lookup(4'd15, 22'h00003);
      check_eq("post_s15_vic_way", 32'(bus.victim_way_o), 32'd1);
      check_eq("post_s15_vic_valid", 32'(bus.victim_valid_o), 32'd1);
      check_eq("post_s15_vic_dirty", 32'(bus.victim_dirty_o), 32'd0);
      check_eq("post_s15_vic_tag", 32'(bus.victim_tag_o), 32'h2FFFF);

      // Clean flush: 32 busy cycles, lookup during busy ignored
      done_before = done_cnt;
      bus.flush_i = 1'b1;
      step();
      clear_cmds();
      busy_cnt = 0;
      saw_rsp  = 1'b0;
      for (int i = 0; i < 100 && bus.busy_o; i++) begin
         busy_cnt++;
         if (bus.rsp_valid_o) saw_rsp = 1'b1;
         bus.index_i  = 4'd1;
         bus.tag_i    = 22'h11111;
         bus.lookup_i = (i == 0);
         step();
      end
      clear_cmds();
      check_eq("clean_busy_cycles", 32'(busy_cnt), 32'd32);
      check_eq("clean_no_rsp", 32'(saw_rsp), 32'd0);
      check_eq("clean_done", 32'(bus.flush_done_o), 32'd1);
      step();
      check_eq("clean_done_pulse", 32'(bus.flush_done_o), 32'd0);
      check_eq("clean_done_count", 32'(done_cnt - done_before), 32'd1);

      // Reset during an offer aborts the flush
      fill(4'd2, 1'b0, 22'h01234, 1'b1);
      done_before = done_cnt;
      bus.flush_i = 1'b1;
      step();
      clear_cmds();
      wait_wb("abort_offer_valid");
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("abort_wb_valid", 32'(bus.wb_valid_o), 32'd0);
      check_eq("abort_busy", 32'(bus.busy_o), 32'd0);
      check_eq("abort_done", 32'(bus.flush_done_o), 32'd0);
      step();
      step();
      check_eq("abort_no_done", 32'(done_cnt - done_before), 32'd0);
      lookup(4'd2, 22'h01234);
      check_eq("abort_lookup_hit", 32'(bus.hit_o), 32'd0);
      check_eq("abort_lookup_vic_valid", 32'(bus.victim_valid_o), 32'd0);
      lookup(4'd1, 22'h11111);
      check_eq("abort_lookup_s1_hit", 32'(bus.hit_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
